// File: rtl/bio.sv
// bio: board I/O controller driving LEDs and 7-segment digits, debouncing switches and keys with a sticky-press interrupt
module bio #(
    parameter int DB_TICK = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [3:2]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq,
    output logic [8:0]  led_g,
    output logic [17:0] led_r,
    output logic [6:0]  hex7_n,
    output logic [6:0]  hex6_n,
    output logic [6:0]  hex5_n,
    output logic [6:0]  hex4_n,
    output logic [6:0]  hex3_n,
    output logic [6:0]  hex2_n,
    output logic [6:0]  hex1_n,
    output logic [6:0]  hex0_n,
    input  logic        key3_n,
    input  logic        key2_n,
    input  logic        key1_n,
    input  logic [17:0] sw
);
    localparam int CW = (DB_TICK > 2) ? $clog2(DB_TICK) : 1;
    // Key inputs are active-low, so the synchronizer idles at 1 for them
    localparam logic [20:0] SYNC_RST = {3'b111, 18'b0};

    logic [26:0]     led;
    logic [31:0]     hex;
    logic [7:0]      blank;
    logic            ien;
    logic [2:0]      flags;
    logic [2:0]      key_q;
    logic [2:0]      clr;
    logic [20:0]     sync1, sync2, smp, deb, in_s;
    logic [CW-1:0]   cnt;
    logic            tick;
    logic            wr;
    logic [7:0][6:0] hex_o;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    assign ack  = stb;
    assign wr   = stb & we;
    assign tick = (cnt == CW'(DB_TICK - 1));
    assign in_s = sync2 ^ SYNC_RST;
    assign clr  = (wr && addr == 2'd3) ? data_in[23:21] : 3'b0;
    assign {hex7_n, hex6_n, hex5_n, hex4_n, hex3_n, hex2_n, hex1_n, hex0_n} = hex_o;

    // Read mux; idle bus reads as zero
    always_comb begin
        data_out = 32'b0;
        if (stb)
            data_out = (addr == 2'd0) ? {5'b0, led} :
                       (addr == 2'd1) ? hex :
                       (addr == 2'd2) ? {24'b0, blank} :
                                        {ien, 7'b0, flags, deb};
    end

    // Synchronize inputs and debounce by requiring agreement on two consecutive ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
            smp   <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {key3_n, key2_n, key1_n, sw};
            sync2 <= sync1;
            cnt   <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                smp <= in_s;
                for (int i = 0; i < 21; i++)
                    if (in_s[i] == smp[i]) deb[i] <= smp[i];
            end
        end
    end

    // CPU registers and sticky press flags; a press edge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            led   <= '0;
            hex   <= '0;
            blank <= 8'hFF;
            ien   <= 1'b0;
            flags <= '0;
            key_q <= '0;
            irq   <= 1'b0;
        end else begin
            if (wr && addr == 2'd0) led <= data_in[26:0];
            if (wr && addr == 2'd1) hex <= data_in;
            if (wr && addr == 2'd2) blank <= data_in[7:0];
            if (wr && addr == 2'd3) ien <= data_in[31];
            key_q <= deb[20:18];
            flags <= (flags & ~clr) | (deb[20:18] & ~key_q);
            irq   <= ien & |flags;
        end
    end

    // Registered board outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= '0;
            led_g <= '0;
            hex_o <= {8{7'h7F}};
        end else begin
            led_r <= led[17:0];
            led_g <= led[26:18];
            for (int i = 0; i < 8; i++)
                hex_o[i] <= blank[i] ? 7'h7F : seg(hex[4*i +: 4]);
        end
    end
endmodule

// File: tb/tb_bio.sv
// tb_bio: directed self-checking bench for bio with a short debounce period
module tb_bio;
    logic        clk = 0, rst = 1, stb = 0, we = 0;
    logic [3:2]  addr = 0;
    logic [31:0] data_in = 0, data_out, d;
    logic        ack, irq;
    logic [8:0]  led_g;
    logic [17:0] led_r, sw = 0;
    logic [6:0]  hex7_n, hex6_n, hex5_n, hex4_n, hex3_n, hex2_n, hex1_n, hex0_n;
    logic        key3_n = 1, key2_n = 1, key1_n = 1;
    int          tests = 0, fails = 0;
    logic        stable, found;

    bio #(.DB_TICK(4)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack), .irq(irq), .led_g(led_g), .led_r(led_r),
        .hex7_n(hex7_n), .hex6_n(hex6_n), .hex5_n(hex5_n), .hex4_n(hex4_n),
        .hex3_n(hex3_n), .hex2_n(hex2_n), .hex1_n(hex1_n), .hex0_n(hex0_n),
        .key3_n(key3_n), .key2_n(key2_n), .key1_n(key1_n), .sw(sw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:2] a, input logic [31:0] v);
        stb = 1; we = 1; addr = a; data_in = v;
        step(1);
        stb = 0; we = 0;
    endtask

    task automatic rd(input logic [3:2] a, output logic [31:0] v);
        stb = 1; we = 0; addr = a;
        #1 v = data_out;
        stb = 0;
    endtask

    initial begin
        step(3);
        rst = 0;
        step(1);
        chk("rst_led_r", 32'(led_r), 0);
        chk("rst_led_g", 32'(led_g), 0);
        chk("rst_hex", {hex7_n, hex4_n, hex0_n}, {3{7'h7F}});
        chk("rst_irq", 32'(irq), 0);
        rd(3, d); chk("rst_input", d, 0);
        rd(2, d); chk("rst_blank", d, 32'hFF);
        stb = 1; #1 chk("ack_comb", 32'(ack), 1); stb = 0;
        #1 chk("idle_dout", data_out, 0);

        wr(0, 32'h07FF_FFFF);
        rd(0, d); chk("led_readback", d, 32'h07FF_FFFF);
        step(1);
        chk("led_r_all", 32'(led_r), 32'h3FFFF);
        chk("led_g_all", 32'(led_g), 32'h1FF);
        wr(1, 32'h0123_ABCF);
        wr(2, 32'h0000_0000);
        step(1);
        chk("hex7_0", 32'(hex7_n), 32'h40);
        chk("hex6_1", 32'(hex6_n), 32'h79);
        chk("hex5_2", 32'(hex5_n), 32'h24);
        chk("hex4_3", 32'(hex4_n), 32'h30);
        chk("hex3_A", 32'(hex3_n), 32'h08);
        chk("hex2_b", 32'(hex2_n), 32'h03);
        chk("hex1_C", 32'(hex1_n), 32'h46);
        chk("hex0_F", 32'(hex0_n), 32'h0E);
        wr(2, 32'h0000_0001);
        step(1);
        chk("hex0_blank", 32'(hex0_n), 32'h7F);
        chk("hex1_kept", 32'(hex1_n), 32'h46);

        sw = 18'h2A5A5;
        step(1);
        rd(3, d); chk("sw_not_yet", d & 32'h3FFFF, 0);
        step(11);
        rd(3, d); chk("sw_debounced", d & 32'h3FFFF, 32'h2A5A5);
        sw[0] = 0;
        step(3);
        sw[0] = 1;
        stable = 1;
        for (int i = 0; i < 16; i++) begin
            rd(3, d);
            if (d[0] !== 1'b1) stable = 0;
            step(1);
        end
        chk("sw_glitch", 32'(stable), 1);

        wr(3, 32'h8000_0000);
        key2_n = 0;
        step(16);
        rd(3, d);
        chk("key2_level", 32'(d[19]), 1);
        chk("key2_flag", 32'(d[22]), 1);
        chk("key2_irq", 32'(irq), 1);
        key2_n = 1;
        step(16);
        rd(3, d);
        chk("key2_released", 32'(d[19]), 0);
        chk("key2_flag_sticky", 32'(d[22]), 1);
        chk("key2_irq_sticky", 32'(irq), 1);
        wr(3, 32'h8040_0000);
        chk("clr_irq_1edge", 32'(irq), 1);
        step(1);
        chk("clr_irq_2edge", 32'(irq), 0);
        rd(3, d); chk("clr_flags", d & 32'h80E0_0000, 32'h8000_0000);

        key1_n = 0;
        found = 0;
        stb = 1; we = 0; addr = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (data_out[18]) found = 1;
        end
        chk("key1_deb_seen", 32'(found), 1);
        chk("key1_flag_before", 32'(data_out[21]), 0);
        we = 1; data_in = 32'h8020_0000;
        step(1);
        stb = 0; we = 0;
        rd(3, d); chk("collide_flag1", 32'(d[21]), 1);
        step(1);
        chk("collide_irq", 32'(irq), 1);
        key1_n = 1;
        wr(3, 32'h8020_0000);
        step(16);

        key3_n = 0;
        wr(0, 32'h1);
        step(16);
        rd(3, d); chk("key3_flag", 32'(d[23]), 1);
        chk("pre_rst_led", 32'(led_r), 1);
        chk("pre_rst_irq", 32'(irq), 1);
        rst = 1; stb = 1; we = 1; addr = 0; data_in = 32'h0003_FFFF;
        step(1);
        rst = 0; stb = 0; we = 0;
        chk("mid_rst_led_r", 32'(led_r), 0);
        chk("mid_rst_hex", {hex7_n, hex0_n}, {2{7'h7F}});
        chk("mid_rst_irq", 32'(irq), 0);
        rd(3, d); chk("mid_rst_input", d, 0);
        rd(0, d); chk("mid_rst_write_dropped", d, 0);
        key3_n = 1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
